// File: rtl/dsp_pkg.sv
// dsp_pkg: shared widths and CIC geometry for the 4X decimator
package dsp_pkg;
  localparam int DW = 18;
  localparam int GW = 4;
  localparam int IW = DW + GW;
  localparam int CIC_R = 4;
  localparam int CIC_N = 2;
endpackage

// File: rtl/cic_stage.sv
// cic_stage: one modular integrator and one comb with independent enables
module cic_stage
  import dsp_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en_int,
  input  logic                 en_comb,
  input  logic signed [IW-1:0] int_in,
  input  logic signed [IW-1:0] comb_in,
  output logic signed [IW-1:0] int_out,
  output logic signed [IW-1:0] comb_out
);
  logic signed [IW-1:0] comb_d;
  always_ff @(posedge clock) begin
    if (reset) begin
      int_out  <= '0;
      comb_out <= '0;
      comb_d   <= '0;
    end else begin
      if (en_int) int_out <= int_out + int_in;
      if (en_comb) begin
        comb_out <= comb_in - comb_d;
        comb_d   <= comb_in;
      end
    end
  end
endmodule

// File: rtl/decim4x.sv
// decim4x: 2nd-order CIC decimate-by-4 with clock-enable phase monitor
module decim4x
  import dsp_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clken4x,
  input  logic                 clkenout,
  input  logic signed [DW-1:0] xkin,
  output logic signed [DW-1:0] ykout,
  output logic                 phaseerr
);
  logic signed [DW-1:0] xr;
  logic signed [IW-1:0] i1, i2, c1, c2;
  logic [1:0] ph;
  logic armed, bad;
  cic_stage s1 (
    .clock(clock), .reset(reset), .en_int(clken4x), .en_comb(clkenout),
    .int_in({{GW{xr[DW-1]}}, xr}), .comb_in(i2), .int_out(i1), .comb_out(c1)
  );
  cic_stage s2 (
    .clock(clock), .reset(reset), .en_int(clken4x), .en_comb(clkenout),
    .int_in(i1), .comb_in(c1), .int_out(i2), .comb_out(c2)
  );
  always_comb bad = clkenout && (!clken4x || (armed && ph != 2'd3));
  always_ff @(posedge clock) begin
    if (reset) begin
      xr       <= '0;
      ykout    <= '0;
      ph       <= '0;
      armed    <= 1'b0;
      phaseerr <= 1'b0;
    end else begin
      if (clken4x) xr <= xkin;
      ph <= clkenout ? 2'd0 : ph + {1'b0, clken4x};
      if (clkenout) begin
        armed <= 1'b1;
        ykout <= c2[IW-1:GW];
      end
      if (bad) phaseerr <= 1'b1;
    end
  end
endmodule

// File: tb/tb_decim4x.sv
// tb_decim4x: directed self-checking bench for the 4X CIC decimator
module tb_decim4x;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clken4x = 1'b0;
  logic clkenout = 1'b0;
  logic signed [17:0] xkin = '0;
  logic signed [17:0] ykout;
  logic phaseerr;
  int checks = 0;
  int failures = 0;

  decim4x dut (
    .clock(clock), .reset(reset), .clken4x(clken4x), .clkenout(clkenout),
    .xkin(xkin), .ykout(ykout), .phaseerr(phaseerr)
  );

  always #5 clock = ~clock;

  task automatic tick(input logic c4, input logic co, input logic signed [17:0] x);
    clken4x = c4;
    clkenout = co;
    xkin = x;
    @(posedge clock);
    #1;
  endtask

  task automatic frame(input logic signed [17:0] x);
    repeat (3) tick(1'b1, 1'b0, x);
    tick(1'b1, 1'b1, x);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick(1'b1, 1'b1, 18'sd12345);
    checks++;
    if (ykout !== 18'sd0) begin
      failures++;
      $display("FAIL reset_ykout got=%0d exp=0", ykout);
    end
    checks++;
    if (phaseerr !== 1'b0) begin
      failures++;
      $display("FAIL reset_phaseerr got=%0b exp=0", phaseerr);
    end
    reset = 1'b0;
  endtask

  task automatic test_dc();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      frame(18'sd1000);
      if (k >= 5) begin
        checks++;
        if (ykout !== 18'sd1000) begin
          failures++;
          $display("FAIL dc_frame%0d got=%0d exp=1000", k, ykout);
        end
      end
    end
    checks++;
    if (phaseerr !== 1'b0) begin
      failures++;
      $display("FAIL dc_phaseerr got=%0b exp=0", phaseerr);
    end
  endtask

  task automatic test_negfs();
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      frame(-18'sd131072);
      if (k >= 5) begin
        checks++;
        if (ykout !== -18'sd131072) begin
          failures++;
          $display("FAIL negfs_frame%0d got=%0d exp=-131072", k, ykout);
        end
      end
    end
    checks++;
    if (phaseerr !== 1'b0) begin
      failures++;
      $display("FAIL negfs_phaseerr got=%0b exp=0", phaseerr);
    end
  endtask

  task automatic test_impulse();
    for (int p = 0; p < 4; p++) begin
      int sum;
      sum = 0;
      do_reset();
      frame('0);
      frame('0);
      for (int t = 0; t < 4; t++) tick(1'b1, t == 3, t == p ? 18'sd1600 : 18'sd0);
      sum += ykout;
      for (int k = 0; k < 8; k++) begin
        frame('0);
        sum += ykout;
      end
      checks++;
      if (sum !== 400) begin
        failures++;
        $display("FAIL impulse_phase%0d sum got=%0d exp=400", p, sum);
      end
    end
  endtask

  task automatic test_nyquist();
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      for (int t = 0; t < 4; t++) tick(1'b1, t == 3, t[0] ? -18'sd8000 : 18'sd8000);
      if (k >= 6) begin
        checks++;
        if (ykout !== 18'sd0) begin
          failures++;
          $display("FAIL nyquist_frame%0d got=%0d exp=0", k, ykout);
        end
      end
    end
  endtask

  task automatic test_misalign();
    do_reset();
    repeat (4) frame('0);
    checks++;
    if (phaseerr !== 1'b0) begin
      failures++;
      $display("FAIL lock_phaseerr got=%0b exp=0", phaseerr);
    end
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, '0);
    checks++;
    if (phaseerr !== 1'b1) begin
      failures++;
      $display("FAIL short_frame_phaseerr got=%0b exp=1", phaseerr);
    end
    repeat (3) frame('0);
    checks++;
    if (phaseerr !== 1'b1) begin
      failures++;
      $display("FAIL sticky_phaseerr got=%0b exp=1", phaseerr);
    end
    do_reset();
    checks++;
    if (phaseerr !== 1'b0) begin
      failures++;
      $display("FAIL reset_clears_phaseerr got=%0b exp=0", phaseerr);
    end
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, '0);
    checks++;
    if (phaseerr !== 1'b0) begin
      failures++;
      $display("FAIL first_clkenout_phaseerr got=%0b exp=0", phaseerr);
    end
    frame('0);
    checks++;
    if (phaseerr !== 1'b0) begin
      failures++;
      $display("FAIL aligned_after_arm_phaseerr got=%0b exp=0", phaseerr);
    end
    repeat (7) tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, '0);
    checks++;
    if (phaseerr !== 1'b0) begin
      failures++;
      $display("FAIL ph_wrap_phaseerr got=%0b exp=0", phaseerr);
    end
    repeat (3) tick(1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, '0);
    checks++;
    if (phaseerr !== 1'b1) begin
      failures++;
      $display("FAIL out_without_4x_phaseerr got=%0b exp=1", phaseerr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (8) frame(18'sd5000);
    checks++;
    if (ykout !== 18'sd5000) begin
      failures++;
      $display("FAIL pre_reset_ykout got=%0d exp=5000", ykout);
    end
    reset = 1'b1;
    tick(1'b1, 1'b1, 18'sd5000);
    checks++;
    if (ykout !== 18'sd0) begin
      failures++;
      $display("FAIL mid_reset_ykout got=%0d exp=0", ykout);
    end
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      frame(18'sd5000);
      if (k <= 2) begin
        checks++;
        if (ykout !== 18'sd0) begin
          failures++;
          $display("FAIL post_reset_frame%0d got=%0d exp=0", k, ykout);
        end
      end else if (k >= 5) begin
        checks++;
        if (ykout !== 18'sd5000) begin
          failures++;
          $display("FAIL post_reset_frame%0d got=%0d exp=5000", k, ykout);
        end
      end
    end
    checks++;
    if (phaseerr !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_phaseerr got=%0b exp=0", phaseerr);
    end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_negfs();
    test_impulse();
    test_nyquist();
    test_misalign();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
